// File: rtl/nd_bus_mem_responder.sv
// ND bus target agent for memory boards: decodes the window, runs one RAM word access per bus
// cycle and completes the handshake with BDRY_n, or with BERROR_n if the RAM never answers.
module nd_bus_mem_responder #(
  parameter int unsigned BASE_PAGE   = 0,
  parameter int unsigned WIN_BITS    = 16,
  parameter int unsigned TOUT_CYCLES = 255
) (
  input  logic                sysclk,
  input  logic                sys_rst_n,
  input  logic                BAPR_n,
  input  logic                BDAP_n,
  input  logic                BINPUT_n,
  input  logic                BMEM_n,
  input  logic                BREF_n,
  input  logic [23:0]         BD_23_0_n_IN,
  output logic [23:0]         BD_23_0_n_OUT,
  output logic                BD_OE,
  output logic                BDRY_n,
  output logic                BERROR_n,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [WIN_BITS-1:0] MEM_ADDR,
  output logic [15:0]         MEM_WDATA,
  input  logic [15:0]         MEM_RDATA,
  input  logic                MEM_ACK,
  output logic                BUSY
);

  localparam int unsigned          PageBits  = 24 - WIN_BITS;
  localparam logic [PageBits-1:0]  PageMatch = PageBits'(BASE_PAGE);
  localparam logic [15:0]          ToutLast  = 16'(TOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StRdMem,
    StRdWait,
    StRdSetup,
    StWrWait,
    StWrMem,
    StHold,
    StErr,
    StFlush
  } state_e;

  state_e      state_q;
  logic        bapr_s1_q, bapr_s2_q, bapr_prev_q;
  logic        bdap_s1_q, bdap_s2_q;
  logic [15:0] rdata_q;
  logic [15:0] tout_cnt_q;

  logic [23:0] bd_addr;
  logic        hit;
  logic        bapr_fall;
  logic        abort;
  logic        tout;

  assign bd_addr   = ~BD_23_0_n_IN;
  assign hit       = !BMEM_n && BREF_n && (bd_addr[23:WIN_BITS] == PageMatch);
  assign bapr_fall = bapr_prev_q && !bapr_s2_q;
  assign abort     = bapr_s2_q;
  assign tout      = MEM_REQ && !MEM_ACK && (tout_cnt_q == ToutLast);
  assign BUSY      = (state_q != StIdle);

  // Synchronisers reset to "strobe asserted" so a BAPR_n held low through reset
  // must be seen high before it can open a cycle.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      bapr_s1_q     <= 1'b0;
      bapr_s2_q     <= 1'b0;
      bapr_prev_q   <= 1'b0;
      bdap_s1_q     <= 1'b1;
      bdap_s2_q     <= 1'b1;
      rdata_q       <= 16'h0000;
      tout_cnt_q    <= 16'h0000;
      BD_23_0_n_OUT <= 24'hFFFFFF;
      BD_OE         <= 1'b0;
      BDRY_n        <= 1'b1;
      BERROR_n      <= 1'b1;
      MEM_REQ       <= 1'b0;
      MEM_WE        <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WDATA     <= 16'h0000;
    end else begin
      bapr_s1_q   <= BAPR_n;
      bapr_s2_q   <= bapr_s1_q;
      bapr_prev_q <= bapr_s2_q;
      bdap_s1_q   <= BDAP_n;
      bdap_s2_q   <= bdap_s1_q;

      if (MEM_REQ && !MEM_ACK) begin
        tout_cnt_q <= tout_cnt_q + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (bapr_fall && hit) begin
            MEM_ADDR <= bd_addr[WIN_BITS-1:0];
            if (!BINPUT_n) begin
              MEM_REQ    <= 1'b1;
              MEM_WE     <= 1'b0;
              tout_cnt_q <= 16'h0000;
              state_q    <= StRdMem;
            end else begin
              state_q <= StWrWait;
            end
          end
        end

        StRdMem: begin
          if (MEM_ACK) begin
            rdata_q <= MEM_RDATA;
            MEM_REQ <= 1'b0;
            state_q <= abort ? StIdle : StRdWait;
          end else if (tout) begin
            MEM_REQ <= 1'b0;
            state_q <= abort ? StIdle : StErr;
          end else if (abort) begin
            state_q <= StFlush;
          end
        end

        StRdWait: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (!bdap_s2_q) begin
            BD_OE         <= 1'b1;
            BD_23_0_n_OUT <= {8'hFF, ~rdata_q};
            state_q       <= StRdSetup;
          end
        end

        // One cycle of data setup on the bus before BDRY_n falls.
        StRdSetup: begin
          if (abort) begin
            BD_OE         <= 1'b0;
            BD_23_0_n_OUT <= 24'hFFFFFF;
            state_q       <= StIdle;
          end else begin
            BDRY_n  <= 1'b0;
            state_q <= StHold;
          end
        end

        StWrWait: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (!bdap_s2_q) begin
            MEM_WDATA  <= ~BD_23_0_n_IN[15:0];
            MEM_REQ    <= 1'b1;
            MEM_WE     <= 1'b1;
            tout_cnt_q <= 16'h0000;
            state_q    <= StWrMem;
          end
        end

        StWrMem: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            if (abort) begin
              state_q <= StIdle;
            end else begin
              BDRY_n  <= 1'b0;
              state_q <= StHold;
            end
          end else if (tout) begin
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            state_q <= abort ? StIdle : StErr;
          end else if (abort) begin
            state_q <= StFlush;
          end
        end

        StHold: begin
          if (bdap_s2_q) begin
            BDRY_n        <= 1'b1;
            BD_OE         <= 1'b0;
            BD_23_0_n_OUT <= 24'hFFFFFF;
            state_q       <= StIdle;
          end
        end

        // A master that drops BAPR_n without ever sending BDAP_n must not wedge us here.
        StErr: begin
          if (!bdap_s2_q) begin
            BERROR_n <= 1'b0;
          end else if (!BERROR_n) begin
            BERROR_n <= 1'b1;
            state_q  <= StIdle;
          end else if (abort) begin
            state_q <= StIdle;
          end
        end

        StFlush: begin
          if (MEM_ACK || tout) begin
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nd_bus_mem_responder.sv
// Randomised bench for nd_bus_mem_responder: the bench plays bus master and RAM, and predicts
// every observable result from a word-level memory image and the bus protocol timing.
module tb_nd_bus_mem_responder;

  logic        sysclk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        BAPR_n = 1'b1;
  logic        BDAP_n = 1'b1;
  logic        BINPUT_n = 1'b1;
  logic        BMEM_n = 1'b1;
  logic        BREF_n = 1'b1;
  logic [23:0] BD_23_0_n_IN = 24'hFFFFFF;
  logic [23:0] BD_23_0_n_OUT;
  logic        BD_OE;
  logic        BDRY_n;
  logic        BERROR_n;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA = 16'h0000;
  logic        MEM_ACK = 1'b0;
  logic        BUSY;

  nd_bus_mem_responder #(
    .BASE_PAGE  (0),
    .WIN_BITS   (16),
    .TOUT_CYCLES(4)
  ) dut (
    .sysclk       (sysclk),
    .sys_rst_n    (sys_rst_n),
    .BAPR_n       (BAPR_n),
    .BDAP_n       (BDAP_n),
    .BINPUT_n     (BINPUT_n),
    .BMEM_n       (BMEM_n),
    .BREF_n       (BREF_n),
    .BD_23_0_n_IN (BD_23_0_n_IN),
    .BD_23_0_n_OUT(BD_23_0_n_OUT),
    .BD_OE        (BD_OE),
    .BDRY_n       (BDRY_n),
    .BERROR_n     (BERROR_n),
    .MEM_REQ      (MEM_REQ),
    .MEM_WE       (MEM_WE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_ACK      (MEM_ACK),
    .BUSY         (BUSY)
  );

  always #5 sysclk = ~sysclk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // ram is what the DUT really reaches; exp_mem is what the bench intended to store.
  logic [15:0] ram     [65536];
  logic [15:0] exp_mem [65536];

  logic        req_prev = 1'b0;
  int unsigned req_rises = 0;
  int unsigned oe_cycles = 0;
  int unsigned dry_low = 0;
  int unsigned err_low = 0;
  int unsigned both_low = 0;

  always @(negedge sysclk) begin
    req_prev <= MEM_REQ;
    if (MEM_REQ && !req_prev) req_rises <= req_rises + 1;
    if (BD_OE) oe_cycles <= oe_cycles + 1;
    if (!BDRY_n) dry_low <= dry_low + 1;
    if (!BERROR_n) err_low <= err_low + 1;
    if (!BDRY_n && !BERROR_n) both_low <= both_low + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic bus_release();
    BAPR_n       = 1'b1;
    BDAP_n       = 1'b1;
    BINPUT_n     = 1'b1;
    BMEM_n       = 1'b1;
    BREF_n       = 1'b1;
    BD_23_0_n_IN = 24'hFFFFFF;
    repeat (5) tick();
  endtask

  task automatic ack_pulse();
    if (MEM_WE) ram[MEM_ADDR] = MEM_WDATA;
    else MEM_RDATA = ram[MEM_ADDR];
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'($urandom);
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic rd);
    BD_23_0_n_IN = ~addr;
    BMEM_n       = 1'b0;
    BREF_n       = 1'b1;
    BINPUT_n     = ~rd;
    BAPR_n       = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int cyc = 0;
    while (!MEM_REQ && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq(tag, cyc, 3);
  endtask

  task automatic do_read(input logic [23:0] addr, input int ack_dly, input int dap_dly);
    logic [15:0] a;
    logic [23:0] exp_bd;
    int unsigned r0;
    int          cyc;
    a      = addr[15:0];
    exp_bd = {8'hFF, ~exp_mem[a]};
    r0     = req_rises;
    start_cycle(addr, 1'b1);
    wait_req("rd_req_latency");
    check_eq("rd_addr", MEM_ADDR, a);
    check_eq("rd_we", MEM_WE, 1'b0);
    repeat (ack_dly - 1) tick();
    ack_pulse();
    check_eq("rd_req_drop", MEM_REQ, 1'b0);
    repeat (dap_dly) tick();
    BDAP_n       = 1'b0;
    BD_23_0_n_IN = 24'hFFFFFF;
    cyc = 0;
    while (!BD_OE && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("rd_oe_latency", cyc, 3);
    check_eq("rd_setup_dry", BDRY_n, 1'b1);
    tick();
    check_eq("rd_dry_low", BDRY_n, 1'b0);
    check_eq("rd_data", BD_23_0_n_OUT, exp_bd);
    repeat (2) tick();
    check_eq("rd_hold_oe", BD_OE, 1'b1);
    BDAP_n = 1'b1;
    cyc = 0;
    while (!BDRY_n && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("rd_release_latency", cyc, 3);
    check_eq("rd_release_oe", BD_OE, 1'b0);
    check_eq("rd_release_bd", BD_23_0_n_OUT, 24'hFFFFFF);
    check_eq("rd_release_busy", BUSY, 1'b0);
    // BAPR_n stays low for a while: it must not reopen a cycle.
    repeat (4) tick();
    bus_release();
    check_eq("rd_req_count", req_rises - r0, 1);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [15:0] data, input int ack_dly);
    logic [15:0] a;
    int unsigned r0, o0;
    a  = addr[15:0];
    r0 = req_rises;
    o0 = oe_cycles;
    start_cycle(addr, 1'b0);
    repeat (4) tick();
    check_eq("wr_wait_busy", BUSY, 1'b1);
    check_eq("wr_wait_noreq", MEM_REQ, 1'b0);
    BDAP_n       = 1'b0;
    BD_23_0_n_IN = ~{8'($urandom), data};
    wait_req("wr_req_latency");
    check_eq("wr_we", MEM_WE, 1'b1);
    check_eq("wr_wdata", MEM_WDATA, data);
    check_eq("wr_addr", MEM_ADDR, a);
    repeat (ack_dly - 1) tick();
    ack_pulse();
    check_eq("wr_dry_low", BDRY_n, 1'b0);
    check_eq("wr_req_drop", {MEM_REQ, MEM_WE}, 2'b00);
    BDAP_n = 1'b1;
    repeat (3) tick();
    check_eq("wr_release", BDRY_n, 1'b1);
    bus_release();
    check_eq("wr_no_oe", oe_cycles - o0, 0);
    check_eq("wr_req_count", req_rises - r0, 1);
    exp_mem[a] = data;
  endtask

  task automatic do_miss(input logic [23:0] addr, input logic mem_n, input logic ref_n,
                         input logic rd);
    int unsigned r0, o0, d0;
    r0 = req_rises;
    o0 = oe_cycles;
    d0 = dry_low;
    BD_23_0_n_IN = ~addr;
    BMEM_n       = mem_n;
    BREF_n       = ref_n;
    BINPUT_n     = ~rd;
    BAPR_n       = 1'b0;
    repeat (4) tick();
    check_eq("miss_busy", BUSY, 1'b0);
    BDAP_n = 1'b0;
    repeat (6) tick();
    check_eq("miss_busy_dap", BUSY, 1'b0);
    bus_release();
    check_eq("miss_no_req", req_rises - r0, 0);
    check_eq("miss_no_bus", (oe_cycles - o0) + (dry_low - d0), 0);
  endtask

  task automatic do_timeout(input logic [23:0] addr);
    int n;
    int unsigned d0;
    d0 = dry_low;
    start_cycle(addr, 1'b1);
    wait_req("to_req_latency");
    n = 0;
    while (MEM_REQ && n < 20) begin
      tick();
      n++;
    end
    check_eq("to_req_cycles", n, 4);
    check_eq("to_berror_idle", BERROR_n, 1'b1);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    tick();
    check_eq("to_late_ack", {MEM_REQ, BDRY_n, BERROR_n, BUSY}, 4'b0111);
    BDAP_n = 1'b0;
    n = 0;
    while (BERROR_n && n < 20) begin
      tick();
      n++;
    end
    check_eq("to_berror_latency", n, 3);
    check_eq("to_berror_dry", {BDRY_n, BD_OE}, 2'b10);
    BDAP_n = 1'b1;
    n = 0;
    while (!BERROR_n && n < 20) begin
      tick();
      n++;
    end
    check_eq("to_release_latency", n, 3);
    check_eq("to_release_busy", BUSY, 1'b0);
    bus_release();
    check_eq("to_no_dry", dry_low - d0, 0);
  endtask

  task automatic do_abort(input logic [23:0] addr);
    int unsigned o0, d0, e0;
    o0 = oe_cycles;
    d0 = dry_low;
    e0 = err_low;
    start_cycle(addr, 1'b1);
    wait_req("ab_req_latency");
    BAPR_n = 1'b1;
    repeat (2) tick();
    check_eq("ab_req_held", MEM_REQ, 1'b1);
    ack_pulse();
    check_eq("ab_req_drop", MEM_REQ, 1'b0);
    check_eq("ab_idle", BUSY, 1'b0);
    BDAP_n = 1'b0;
    repeat (6) tick();
    check_eq("ab_still_idle", BUSY, 1'b0);
    bus_release();
    check_eq("ab_no_bus", (oe_cycles - o0) + (dry_low - d0) + (err_low - e0), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {BD_23_0_n_OUT, BD_OE, BDRY_n, BERROR_n, MEM_REQ, MEM_WE, BUSY},
             {24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check_eq({tag, "_addr_wdata"}, {MEM_ADDR, MEM_WDATA}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    int unsigned r0;
    int          n;
    for (int i = 0; i < 65536; i++) begin
      v          = 16'($urandom);
      ram[i]     = v;
      exp_mem[i] = v;
    end

    repeat (3) tick();
    check_reset_outputs("reset_state");
    sys_rst_n = 1'b1;
    repeat (4) tick();
    check_eq("reset_busy", BUSY, 1'b0);

    ram[16'h0042]     = 16'hA5C3;
    exp_mem[16'h0042] = 16'hA5C3;
    do_read(24'h000042, 2, 2);
    do_write(24'h000100, 16'h1234, 2);
    do_read(24'h000100, 1, 0);

    do_miss(24'h010000, 1'b0, 1'b1, 1'b1);
    do_miss(24'h000042, 1'b1, 1'b1, 1'b1);
    do_miss(24'h000042, 1'b0, 1'b0, 1'b1);

    do_timeout(24'h000077);
    do_abort(24'h000042);

    // Asynchronous reset while the read is in HOLD.
    start_cycle(24'h000042, 1'b1);
    wait_req("rh_req_latency");
    ack_pulse();
    BDAP_n = 1'b0;
    n = 0;
    while (BDRY_n && n < 20) begin
      tick();
      n++;
    end
    check_eq("rh_in_hold", {BDRY_n, BD_OE}, 2'b01);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("rh_async_reset");
    tick();
    tick();
    r0 = req_rises;
    sys_rst_n = 1'b1;
    repeat (8) tick();
    check_eq("rh_held_bapr_ignored", {BUSY, MEM_REQ}, 2'b00);
    check_eq("rh_no_req", req_rises - r0, 0);
    bus_release();
    do_read(24'h000042, 1, 1);

    for (int t = 0; t < 40; t++) begin
      logic [23:0] addr;
      int          kind;
      kind = $urandom_range(0, 9);
      addr = {8'h00, 16'h0040 + 16'($urandom_range(0, 7))};
      if (kind < 4) begin
        do_read(addr, $urandom_range(1, 3), $urandom_range(0, 3));
      end else if (kind < 8) begin
        do_write(addr, 16'($urandom), $urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 2))
          0:       do_miss({8'($urandom_range(1, 255)), addr[15:0]}, 1'b0, 1'b1, 1'($urandom));
          1:       do_miss(addr, 1'b1, 1'b1, 1'($urandom));
          default: do_miss(addr, 1'b0, 1'b0, 1'($urandom));
        endcase
      end
    end

    tick();
    check_eq("never_both_low", both_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
